trap_csr_unit: RTL and testbench
================================

Name: trap_csr_unit

Overview:
- Machine-mode trap sequencer and CSR file. It sits directly downstream of the pipeline control unit.
- Consumes the trap request produced there: cause, faulting PC, trap value. Latches mepc/mcause/mtval, flushes the pipeline and redirects fetch to the handler.
- On mret, flushes again and redirects fetch back to mepc.
- Also serves CSR read/modify/write instructions issued from EX.

Parameters:
- MTVEC_RESET, 32'h0000F000, reset value of mtvec (handler base).
- NUM_CAUSES, 16, number of valid cause codes; cause >= NUM_CAUSES is treated as cause 0 (ignored).

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- trap_req  input  1  trap request from pipeline control, level, sampled each posedge.
- trap_cause  input  4  cause code (1 ebreak, 2 user breakpoint, 3 div-by-0, 4 mem access, 5 decode error).
- trap_epc  input  32  return PC to store in mepc.
- trap_tval  input  32  trap value to store in mtval.
- mret_req  input  1  mret executing in EX.
- csr_we  input  1  CSR instruction in EX.
- csr_op  input  2  01 write, 10 set bits, 11 clear bits, 00 read-only.
- csr_addr  input  12  CSR address.
- csr_wdata  input  32  source operand.
- csr_rdata  output  32  old CSR value, combinational.
- csr_illegal  output  1  unknown csr_addr while csr_we, combinational.
- flush  output  1  clear all pipeline registers this cycle.
- redirect_valid  output  1  load PC with redirect_pc this cycle.
- redirect_pc  output  32  fetch target.
- trap_ack  output  1  one-cycle pulse: trap accepted.
- in_trap  output  1  handler executing.
- cpu_halt  output  1  double fault; sticky until reset.

Behaviour:
- CSR map:
  - mscratch 0x340, reset 0.
  - mtvec 0x305, reset MTVEC_RESET.
  - mepc 0x341, reset 0; bits[1:0] always read 0.
  - mcause 0x342, reset 0.
  - mtval 0x343, reset 0.
- Any other address while csr_we: csr_illegal=1, csr_rdata=0, no write.
- CSR write at posedge when csr_we and state IDLE or HANDLER:
  - new = wdata (01), old|wdata (10), old&~wdata (11), none (00).
  - csr_rdata always shows the pre-write value.
- Handler target = {mtvec[31:2],2'b00} + (mtvec[0] ? cause*4 : 0), computed from the latched mcause.
- FSM states: IDLE, T_FLUSH, T_REDIR, HANDLER, R_FLUSH, R_REDIR, HALT.
  - IDLE, trap_req with valid cause != 0 -> T_FLUSH. Same edge latches mepc=trap_epc&~3, mcause=cause, mtval=trap_tval. Any simultaneous csr_we write is dropped (trap wins). mret_req in IDLE is ignored.
  - T_FLUSH: flush=1, trap_ack=1 -> T_REDIR.
  - T_REDIR: redirect_valid=1, redirect_pc=handler target -> HANDLER.
  - HANDLER: in_trap=1.
    - trap_req (valid cause) -> HALT (double fault). Takes priority over mret_req.
    - else mret_req -> R_FLUSH.
  - R_FLUSH: flush=1, in_trap=1 -> R_REDIR.
  - R_REDIR: redirect_valid=1, redirect_pc=mepc, in_trap=0 -> IDLE.
  - HALT: flush=1, cpu_halt=1 held; only rstn exits.
- CSR writes in T_FLUSH/T_REDIR/R_FLUSH/R_REDIR/HALT are dropped.
- trap_req held high across T_FLUSH/T_REDIR is not re-sampled until HANDLER. Pipeline control must drop it once trap_ack has been seen.
- Latency: trap_req sampled at edge N -> flush in cycle N+1 -> redirect in N+2 -> in_trap from N+3.
- Reset:
  - All outputs 0, except redirect_pc = MTVEC_RESET and csr_rdata per address.
  - State IDLE, CSRs at reset values.
  - Asynchronous reset mid-sequence aborts it with no redirect.
- redirect_pc when redirect_valid=0: MTVEC_RESET.

Decomposition:
- Shared package trap_pkg:
  - CSR address constants.
  - cause codes 0..5.
  - csr_op encodings.
  - FSM state enum (3-bit).
- Sub-module csr_regfile: CSR storage, address decode, RMW, illegal detection, write-enable gating.
- trap_csr_unit owns the FSM, the latch strobe into csr_regfile and the redirect mux.

Test Plan:
- Trap entry: reset, trap_req=1 cause=1 epc=0x104 tval=0 for one cycle.
  - Next cycle: flush=1, trap_ack=1.
  - Then: redirect_valid=1, redirect_pc=0xF000.
  - Then: in_trap=1; mepc=0x104, mcause=1.
- Vectored mode: write mtvec=0xF001 (op 01), then trap cause=2 -> redirect_pc=0xF008. csr_rdata for 0x305 reads 0xF001.
- Return path: in HANDLER, csrrs mepc wdata=0x4 (mepc 0x104 -> 0x104), then csrrw mepc=0x10A; mret_req.
  - Response: flush one cycle, then redirect_pc=0x108, then IDLE with in_trap=0.
- Trap/CSR collision: in IDLE, trap_req cause=3 with csr_we op 01 mscratch=0xDEAD simultaneously -> mscratch stays 0, trap sequence proceeds.
- Double fault: in HANDLER, trap_req cause=4 together with mret_req -> HALT, cpu_halt=1 and flush=1 held for 20 cycles; rstn pulse -> cpu_halt=0, mtvec=0xF000.
- Edge cases:
  - csr_addr=0x7C0 with csr_we -> csr_illegal=1, rdata=0.
  - trap_req cause=0 -> no state change.
  - mret_req in IDLE -> no redirect.

Source files
------------

// File: rtl/trap_pkg.sv
// ---------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the machine-mode trap sequencer and its CSR file:
//   - CSR address constants for the five implemented machine CSRs
//   - trap cause codes raised by the pipeline control unit
//   - CSR operation encodings and the read/modify/write helper
//   - the trap sequencer FSM state enum
// ---------------------------------------------------------------------------
package trap_pkg;

  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  typedef enum logic [3:0] {
    CAUSE_NONE      = 4'd0,
    CAUSE_EBREAK    = 4'd1,
    CAUSE_USER_BRK  = 4'd2,
    CAUSE_DIV_ZERO  = 4'd3,
    CAUSE_MEM_FAULT = 4'd4,
    CAUSE_DECODE    = 4'd5
  } trap_cause_e;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_T_FLUSH = 3'd1,
    ST_T_REDIR = 3'd2,
    ST_HANDLER = 3'd3,
    ST_R_FLUSH = 3'd4,
    ST_R_REDIR = 3'd5,
    ST_HALT    = 3'd6
  } trap_state_e;

  // New CSR value for a given operation; a read-only op returns the old value.
  function automatic logic [31:0] csr_rmw(input logic [1:0] op,
                                          input logic [31:0] old_val,
                                          input logic [31:0] src);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSR_OP_WRITE: res = src;
      CSR_OP_SET:   res = old_val | src;
      CSR_OP_CLEAR: res = old_val & ~src;
      default:      res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/trap_csr_unit_if.sv
// ---------------------------------------------------------------------------
// trap_csr_unit_if
// Bundle between the pipeline (master) and the trap/CSR unit (slave).
//   Pipeline -> unit : trap_req, trap_cause, trap_epc, trap_tval, mret_req,
//                      csr_we, csr_op, csr_addr, csr_wdata
//   Unit -> pipeline : csr_rdata, csr_illegal, flush, redirect_valid,
//                      redirect_pc, trap_ack, in_trap, cpu_halt
// ---------------------------------------------------------------------------
interface trap_csr_unit_if;

  logic        trap_req;
  logic [3:0]  trap_cause;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic        mret_req;
  logic        csr_we;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_ack;
  logic        in_trap;
  logic        cpu_halt;

  modport master (
    output trap_req, trap_cause, trap_epc, trap_tval, mret_req,
           csr_we, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, csr_illegal, flush, redirect_valid, redirect_pc,
           trap_ack, in_trap, cpu_halt
  );

  modport slave (
    input  trap_req, trap_cause, trap_epc, trap_tval, mret_req,
           csr_we, csr_op, csr_addr, csr_wdata,
    output csr_rdata, csr_illegal, flush, redirect_valid, redirect_pc,
           trap_ack, in_trap, cpu_halt
  );

endinterface

// File: rtl/trap_csr_unit_csr_regfile.sv
// ---------------------------------------------------------------------------
// csr_regfile
// Machine CSR storage (mscratch, mtvec, mepc, mcause, mtval) with address
// decode, read/modify/write, illegal-address detection and a trap latch port.
// Ports:
//   clk, rstn               clock, async active-low reset
//   csr_we/op/addr/wdata    CSR instruction from EX
//   write_allow             sequencer permits a CSR write this edge
//   latch_en/epc/cause/tval trap capture strobe and values (beats CSR writes)
//   csr_rdata, csr_illegal  combinational pre-write read data / bad address
//   mtvec, mepc, mcause     current values for redirect target generation
// ---------------------------------------------------------------------------
module csr_regfile
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000F000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        csr_we,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        write_allow,
  input  logic        latch_en,
  input  logic [31:0] latch_epc,
  input  logic [3:0]  latch_cause,
  input  logic [31:0] latch_tval,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic [31:0] mcause
);

  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mtvec_q,    mtvec_d;
  logic [31:0] mepc_q,     mepc_d;
  logic [31:0] mcause_q,   mcause_d;
  logic [31:0] mtval_q,    mtval_d;

  logic        addr_known;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        do_write;

  // Address decode: csr_rdata follows csr_addr even without csr_we, unknown
  // addresses read as zero.
  always_comb begin
    addr_known = 1'b1;
    old_val    = 32'd0;
    case (csr_addr)
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MTVAL:    old_val = mtval_q;
      default:      addr_known = 1'b0;
    endcase
  end

  assign csr_rdata   = old_val;
  assign csr_illegal = csr_we & ~addr_known;
  assign new_val     = csr_rmw(csr_op, old_val, csr_wdata);
  assign do_write    = csr_we & write_allow & addr_known & (csr_op != CSR_OP_READ);

  // Next-state: trap capture takes precedence over any CSR instruction write.
  // mepc is kept word aligned on every path into it.
  always_comb begin
    mscratch_d = mscratch_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (latch_en) begin
      mepc_d   = latch_epc & ~32'h3;
      mcause_d = {28'd0, latch_cause};
      mtval_d  = latch_tval;
    end else if (do_write) begin
      case (csr_addr)
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MTVEC:    mtvec_d    = new_val;
        CSR_MEPC:     mepc_d     = new_val & ~32'h3;
        CSR_MCAUSE:   mcause_d   = new_val;
        CSR_MTVAL:    mtval_d    = new_val;
        default: ;
      endcase
    end
  end

  // CSR state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mscratch_q <= 32'd0;
      mtvec_q    <= MTVEC_RESET;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
    end else begin
      mscratch_q <= mscratch_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  assign mtvec  = mtvec_q;
  assign mepc   = mepc_q;
  assign mcause = mcause_q;

endmodule

// File: rtl/trap_csr_unit.sv
// ---------------------------------------------------------------------------
// trap_csr_unit
// Machine-mode trap sequencer. Accepts a trap from pipeline control, latches
// mepc/mcause/mtval, flushes and redirects fetch to the handler; on mret
// flushes and redirects back to mepc. A trap while the handler is running
// halts the CPU until reset. Also serves CSR instructions via csr_regfile.
// Ports:
//   clk, rstn   clock, async active-low reset
//   bus         trap_csr_unit_if.slave: trap request, mret, CSR access in;
//               CSR read data, flush, redirect, trap_ack, in_trap, cpu_halt out
// ---------------------------------------------------------------------------
module trap_csr_unit
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000F000,
  parameter int          NUM_CAUSES  = 16
) (
  input logic            clk,
  input logic            rstn,
  trap_csr_unit_if.slave bus
);

  trap_state_e state_q, state_d;

  logic        trap_valid;
  logic        write_allow;
  logic        latch_en;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] handler_pc;

  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_ack;
  logic        in_trap;
  logic        cpu_halt;

  // Cause 0 and out-of-range causes are not traps at all.
  assign trap_valid = bus.trap_req && (bus.trap_cause != 4'd0) &&
                      ({28'd0, bus.trap_cause} < 32'(NUM_CAUSES));

  // Vectored mode (mtvec[0]) offsets the base by 4 bytes per cause code.
  assign handler_pc = {mtvec[31:2], 2'b00} +
                      (mtvec[0] ? {mcause[29:0], 2'b00} : 32'd0);

  csr_regfile #(
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr_regfile (
    .clk         (clk),
    .rstn        (rstn),
    .csr_we      (bus.csr_we),
    .csr_op      (bus.csr_op),
    .csr_addr    (bus.csr_addr),
    .csr_wdata   (bus.csr_wdata),
    .write_allow (write_allow),
    .latch_en    (latch_en),
    .latch_epc   (bus.trap_epc),
    .latch_cause (bus.trap_cause),
    .latch_tval  (bus.trap_tval),
    .csr_rdata   (bus.csr_rdata),
    .csr_illegal (bus.csr_illegal),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .mcause      (mcause)
  );

  // Next-state and Moore outputs. CSR writes are only allowed while the
  // pipeline is running normally (IDLE or HANDLER) and no trap is being
  // taken on the same edge, so a colliding trap always wins.
  always_comb begin
    state_d        = state_q;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = MTVEC_RESET;
    trap_ack       = 1'b0;
    in_trap        = 1'b0;
    cpu_halt       = 1'b0;
    write_allow    = 1'b0;
    latch_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        write_allow = ~trap_valid;
        if (trap_valid) begin
          latch_en = 1'b1;
          state_d  = ST_T_FLUSH;
        end
      end
      ST_T_FLUSH: begin
        flush    = 1'b1;
        trap_ack = 1'b1;
        state_d  = ST_T_REDIR;
      end
      ST_T_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = handler_pc;
        state_d        = ST_HANDLER;
      end
      ST_HANDLER: begin
        in_trap     = 1'b1;
        write_allow = ~trap_valid;
        if (trap_valid) begin
          state_d = ST_HALT;
        end else if (bus.mret_req) begin
          state_d = ST_R_FLUSH;
        end
      end
      ST_R_FLUSH: begin
        flush   = 1'b1;
        in_trap = 1'b1;
        state_d = ST_R_REDIR;
      end
      ST_R_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = mepc;
        state_d        = ST_IDLE;
      end
      ST_HALT: begin
        flush    = 1'b1;
        cpu_halt = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any sequence in flight without a redirect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.flush          = flush;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.trap_ack       = trap_ack;
  assign bus.in_trap        = in_trap;
  assign bus.cpu_halt       = cpu_halt;

endmodule

// File: tb/tb_trap_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_trap_csr_unit
// Drives directed and random traffic into trap_csr_unit. For every cycle the
// stimulus side pushes the expected outputs (from a behavioural model built
// on a queue of scheduled pipeline actions) into a scoreboard queue; a
// separate monitor pops one entry per cycle and compares all outputs.
// ---------------------------------------------------------------------------
module tb_trap_csr_unit;

  localparam logic [31:0] MTVEC_RESET = 32'h0000F000;

  logic clk;
  logic rstn;

  trap_csr_unit_if bus ();

  trap_csr_unit #(
    .MTVEC_RESET (MTVEC_RESET),
    .NUM_CAUSES  (16)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        ack;
    logic        rv;
    logic [31:0] rpc;
    logic        in_trap;
    logic        halt;
    logic [31:0] rdata;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_mscratch, m_mtvec, m_mepc, m_mcause, m_mtval;
  bit          m_handler;
  bit          m_halted;

  function automatic exp_t mk(input logic fl, input logic ak, input logic rv,
                              input logic [31:0] rpc, input logic it);
    exp_t e;
    e = '{default: '0};
    e.flush = fl; e.ack = ak; e.rv = rv; e.rpc = rpc; e.in_trap = it;
    return e;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, output bit known);
    known = 1'b1;
    case (a)
      12'h340: return m_mscratch;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: begin known = 1'b0; return 32'd0; end
    endcase
  endfunction

  task automatic model_reset();
    m_mscratch = 32'd0;
    m_mtvec    = MTVEC_RESET;
    m_mepc     = 32'd0;
    m_mcause   = 32'd0;
    m_mtval    = 32'd0;
    m_handler  = 1'b0;
    m_halted   = 1'b0;
    pend_q.delete();
  endtask

  // What the model does at the next rising edge with the given inputs.
  task automatic model_step(input bit t_req, input logic [3:0] cause,
                            input logic [31:0] epc, input logic [31:0] tval,
                            input bit mret, input bit we, input logic [1:0] op,
                            input logic [11:0] addr, input logic [31:0] wdata);
    bit          known;
    logic [31:0] old, nv, target;
    if (m_halted) return;
    if (pend_q.size() > 0) begin
      void'(pend_q.pop_front());
      return;
    end
    if (t_req && cause != 4'd0) begin
      if (m_handler) begin
        m_halted = 1'b1;
      end else begin
        m_mepc   = epc & ~32'h3;
        m_mcause = 32'(cause);
        m_mtval  = tval;
        target   = (m_mtvec & ~32'h3) + (m_mtvec[0] ? 32'(cause) * 4 : 32'd0);
        pend_q.push_back(mk(1, 1, 0, MTVEC_RESET, 0));
        pend_q.push_back(mk(0, 0, 1, target, 0));
        m_handler = 1'b1;
      end
      return;
    end
    old = model_read(addr, known);
    if (we && known && op != 2'b00) begin
      nv = (op == 2'b01) ? wdata : (op == 2'b10) ? (old | wdata) : (old & ~wdata);
      case (addr)
        12'h340: m_mscratch = nv;
        12'h305: m_mtvec    = nv;
        12'h341: m_mepc     = nv & ~32'h3;
        12'h342: m_mcause   = nv;
        default: m_mtval    = nv;
      endcase
    end
    if (m_handler && mret) begin
      pend_q.push_back(mk(1, 0, 0, MTVEC_RESET, 1));
      pend_q.push_back(mk(0, 0, 1, m_mepc, 0));
      m_handler = 1'b0;
    end
  endtask

  // One cycle of stimulus: drive, push the expected outputs, advance model.
  task automatic apply_stimulus(input bit rst_n, input bit t_req, input logic [3:0] cause,
                                input logic [31:0] epc, input logic [31:0] tval,
                                input bit mret, input bit we, input logic [1:0] op,
                                input logic [11:0] addr, input logic [31:0] wdata);
    exp_t        e;
    bit          known;
    logic [31:0] rd;
    @(posedge clk);
    #2;
    rstn           = rst_n;
    bus.trap_req   = t_req;
    bus.trap_cause = cause;
    bus.trap_epc   = epc;
    bus.trap_tval  = tval;
    bus.mret_req   = mret;
    bus.csr_we     = we;
    bus.csr_op     = op;
    bus.csr_addr   = addr;
    bus.csr_wdata  = wdata;
    if (!rst_n) model_reset();
    if (m_halted) begin
      e = mk(1, 0, 0, MTVEC_RESET, 0);
      e.halt = 1'b1;
    end else if (pend_q.size() > 0) begin
      e = pend_q[0];
    end else begin
      e = mk(0, 0, 0, MTVEC_RESET, m_handler);
    end
    rd        = model_read(addr, known);
    e.rdata   = known ? rd : 32'd0;
    e.illegal = we && !known;
    exp_q.push_back(e);
    if (rst_n) model_step(t_req, cause, epc, tval, mret, we, op, addr, wdata);
  endtask

  task automatic idle(input int n, input logic [11:0] addr);
    for (int k = 0; k < n; k++) apply_stimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, addr, 0);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("flush",          32'(bus.flush),          32'(e.flush));
        check_output("trap_ack",       32'(bus.trap_ack),       32'(e.ack));
        check_output("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
        check_output("redirect_pc",    bus.redirect_pc,         e.rpc);
        check_output("in_trap",        32'(bus.in_trap),        32'(e.in_trap));
        check_output("cpu_halt",       32'(bus.cpu_halt),       32'(e.halt));
        check_output("csr_rdata",      bus.csr_rdata,           e.rdata);
        check_output("csr_illegal",    32'(bus.csr_illegal),    32'(e.illegal));
      end
    end
  end

  initial begin
    bit          r_rst, r_treq, r_mret, r_we;
    logic [3:0]  r_cause;
    logic [1:0]  r_op;
    logic [11:0] r_addr;
    logic [31:0] r_epc, r_tval, r_wdata;

    rstn           = 1'b0;
    bus.trap_req   = 1'b0;
    bus.trap_cause = 4'd0;
    bus.trap_epc   = 32'd0;
    bus.trap_tval  = 32'd0;
    bus.mret_req   = 1'b0;
    bus.csr_we     = 1'b0;
    bus.csr_op     = 2'b00;
    bus.csr_addr   = 12'h305;
    bus.csr_wdata  = 32'd0;
    model_reset();

    // Reset state, then trap entry with ebreak.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 12'h305, 0);
    idle(1, 12'h305);
    apply_stimulus(1, 1, 4'd1, 32'h104, 0, 0, 0, 2'b00, 12'h341, 0);
    idle(2, 12'h341);
    idle(1, 12'h341);
    idle(1, 12'h342);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 2'b00, 12'h341, 0);
    idle(3, 12'h341);

    // Vectored mode, then return path with mepc edits in the handler.
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 2'b01, 12'h305, 32'h0000F001);
    idle(1, 12'h305);
    apply_stimulus(1, 1, 4'd2, 32'h104, 32'h55, 0, 0, 2'b00, 12'h305, 0);
    idle(3, 12'h305);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 2'b10, 12'h341, 32'h4);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 2'b01, 12'h341, 32'h10A);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 2'b00, 12'h341, 0);
    idle(3, 12'h341);

    // Trap colliding with a CSR write: the write is dropped.
    apply_stimulus(1, 1, 4'd3, 32'h200, 32'h7, 0, 1, 2'b01, 12'h340, 32'hDEAD);
    idle(3, 12'h340);

    // Double fault in the handler beats mret; held until reset.
    apply_stimulus(1, 1, 4'd4, 32'h300, 0, 1, 0, 2'b00, 12'h340, 0);
    idle(20, 12'h343);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 12'h305, 0);
    idle(1, 12'h305);

    // Illegal address, cause 0, mret outside a handler.
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 2'b01, 12'h7C0, 32'h55);
    apply_stimulus(1, 1, 4'd0, 32'h400, 0, 0, 0, 2'b00, 12'h341, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 2'b00, 12'h341, 0);
    idle(2, 12'h342);

    // Random traffic, including resets in the middle of sequences.
    for (int i = 0; i < 800; i++) begin
      r_rst   = m_halted ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 149) != 0);
      r_treq  = ($urandom_range(0, 5) == 0);
      r_cause = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      r_epc   = $urandom;
      r_tval  = $urandom;
      r_mret  = ($urandom_range(0, 3) == 0);
      r_we    = ($urandom_range(0, 1) == 0);
      r_op    = 2'($urandom_range(0, 3));
      r_wdata = $urandom;
      case ($urandom_range(0, 6))
        0: r_addr = 12'h340;
        1: r_addr = 12'h305;
        2: r_addr = 12'h341;
        3: r_addr = 12'h342;
        4: r_addr = 12'h343;
        5: r_addr = 12'h7C0;
        default: r_addr = 12'($urandom);
      endcase
      apply_stimulus(r_rst, r_treq, r_cause, r_epc, r_tval, r_mret, r_we, r_op, r_addr, r_wdata);
    end

    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
